// File: rtl/kb_pkg.sv
// Shared constants for the PS/2 keyboard writer: prefixes, modifier scan codes,
// event-word layout and the decoder state encodings.
package kb_pkg;

  localparam logic [31:0] KB_INFO_OFFSET = 32'h0050_0000;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int unsigned EV_EXT     = 8;
  localparam int unsigned EV_BRK     = 9;
  localparam int unsigned EV_SHIFT   = 10;
  localparam int unsigned EV_CTRL    = 11;
  localparam int unsigned EV_CAPS    = 12;
  localparam int unsigned EV_SEQ_LSB = 16;

  localparam logic [2:0] SKIP_LAST = 3'd6;  // Pause tail is 7 bytes after E1

  typedef enum logic [0:0] {RX_IDLE, RX_SHIFT} rx_state_t;
  typedef enum logic [2:0] {NORMAL, GOT_E0, GOT_F0, GOT_E0F0, SKIP} dec_state_t;

  // Keyboard responses (ack, echo, BAT, errors) that never carry a key.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:                                 is_ignored = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] make_event_word(
    input logic [7:0] code, input logic ext, input logic brk,
    input logic shift, input logic ctrl, input logic caps, input logic [7:0] seq);
    logic [31:0] w;
    w                     = '0;
    w[7:0]                = code;
    w[EV_EXT]             = ext;
    w[EV_BRK]             = brk;
    w[EV_SHIFT]           = shift;
    w[EV_CTRL]            = ctrl;
    w[EV_CAPS]            = caps;
    w[EV_SEQ_LSB +: 8]    = seq;
    return w;
  endfunction

endpackage

// File: rtl/ps2_kb_writer_if.sv
// Memory-mapped write port carrying key-event words to the kb_info register.
interface ps2_kb_writer_if;
  logic [31:0] kb_wraddr;
  logic [31:0] kb_wrdata;
  logic        kb_we;

  modport master (output kb_wraddr, output kb_wrdata, output kb_we);
  modport slave  (input  kb_wraddr, input  kb_wrdata, input  kb_we);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizer, falling-edge detect, 11-bit frame FSM,
// odd-parity/stop check and mid-frame timeout.
module ps2_rx
  import kb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       rx_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t   state, state_nx;
  logic [1:0]  clk_sync, data_sync;
  logic        clk_prev, fall, din;
  logic [3:0]  bit_cnt;
  logic [8:0]  shreg;
  logic [CW-1:0] idle_cnt;
  logic        frame_done, frame_ok, timeout;

  assign fall = clk_prev & ~clk_sync[1];
  assign din  = data_sync[1];

  // Lines idle high, so the synchronizers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_IDLE;
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_prev   <= 1'b1;
      bit_cnt    <= '0;
      shreg      <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      rx_err     <= 1'b0;
    end else begin
      state     <= state_nx;
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
      if (fall)
        idle_cnt <= '0;
      else if (idle_cnt != CW'(TIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + 1'b1;
      if (fall && state == RX_IDLE)
        bit_cnt <= '0;
      else if (fall && state == RX_SHIFT) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt < 4'd9) shreg <= {din, shreg[8:1]};
      end
      byte_valid <= frame_done && frame_ok;
      rx_err     <= (frame_done && !frame_ok) || timeout;
      if (frame_done) rx_byte <= shreg[7:0];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RX_IDLE:  if (fall && !din) state_nx = RX_SHIFT;
      RX_SHIFT: if (frame_done || timeout) state_nx = RX_IDLE;
      default:  state_nx = RX_IDLE;
    endcase
  end

  // shreg holds {parity, data[7:0]}; the stop bit is the live sample.
  always_comb begin
    frame_done = fall && state == RX_SHIFT && bit_cnt == 4'd9;
    frame_ok   = (^shreg) && din;
    timeout    = state == RX_SHIFT && !fall && idle_cnt == CW'(TIMEOUT_CYCLES);
  end

endmodule

// File: rtl/ps2_kb_writer.sv
// Scan-code decoder, modifier tracking and kb_info write port fed by ps2_rx.
module ps2_kb_writer
  import kb_pkg::*;
#(
  parameter logic [31:0] KB_ADDR        = KB_INFO_OFFSET,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  ps2_kb_writer_if.master        kb,
  output logic                   rx_err
);

  logic       byte_valid;
  logic [7:0] rx_byte;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .rx_err     (rx_err)
  );

  dec_state_t state, state_nx;
  logic [2:0] skip_cnt;
  logic [7:0] seq;
  logic       shift, ctrl, caps, caps_held;
  logic       key_evt, ext, brk;
  logic       shift_nx, ctrl_nx, caps_nx, caps_held_nx;

  assign kb.kb_wraddr = KB_ADDR;

  always_ff @(posedge clk) begin
    if (reset) state <= NORMAL;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (byte_valid) begin
      unique case (state)
        NORMAL: begin
          if      (rx_byte == PFX_E0) state_nx = GOT_E0;
          else if (rx_byte == PFX_F0) state_nx = GOT_F0;
          else if (rx_byte == PFX_E1) state_nx = SKIP;
        end
        GOT_E0:           state_nx = (rx_byte == PFX_F0) ? GOT_E0F0 : NORMAL;
        GOT_F0, GOT_E0F0: state_nx = NORMAL;
        SKIP:             if (skip_cnt == SKIP_LAST) state_nx = NORMAL;
        default:          state_nx = NORMAL;
      endcase
    end
  end

  always_comb begin
    key_evt = 1'b0;
    ext     = 1'b0;
    brk     = 1'b0;
    if (byte_valid) begin
      unique case (state)
        NORMAL:   key_evt = rx_byte != PFX_E0 && rx_byte != PFX_F0 &&
                            rx_byte != PFX_E1 && !is_ignored(rx_byte);
        GOT_E0:   begin key_evt = rx_byte != PFX_F0; ext = 1'b1; end
        GOT_F0:   begin key_evt = 1'b1; brk = 1'b1; end
        GOT_E0F0: begin key_evt = 1'b1; ext = 1'b1; brk = 1'b1; end
        default:  key_evt = 1'b0;
      endcase
    end
  end

  // Modifier next-state: the event word reports the already-updated flags.
  always_comb begin
    shift_nx     = shift;
    ctrl_nx      = ctrl;
    caps_nx      = caps;
    caps_held_nx = caps_held;
    if (key_evt) begin
      if ((rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) && !ext) shift_nx = !brk;
      if (rx_byte == SC_CTRL) ctrl_nx = !brk;
      if (rx_byte == SC_CAPS && !ext) begin
        if (brk)
          caps_held_nx = 1'b0;
        else if (!caps_held) begin
          caps_nx      = !caps;
          caps_held_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skip_cnt     <= '0;
      seq          <= '0;
      shift        <= 1'b0;
      ctrl         <= 1'b0;
      caps         <= 1'b0;
      caps_held    <= 1'b0;
      kb.kb_we     <= 1'b0;
      kb.kb_wrdata <= '0;
    end else begin
      if (byte_valid) begin
        if (state == NORMAL && rx_byte == PFX_E1) skip_cnt <= '0;
        else if (state == SKIP)                   skip_cnt <= skip_cnt + 3'd1;
      end
      kb.kb_we <= key_evt;
      if (key_evt) begin
        shift        <= shift_nx;
        ctrl         <= ctrl_nx;
        caps         <= caps_nx;
        caps_held    <= caps_held_nx;
        seq          <= seq + 8'd1;
        kb.kb_wrdata <= make_event_word(rx_byte, ext, brk, shift_nx, ctrl_nx,
                                        caps_nx, seq + 8'd1);
      end
    end
  end

endmodule
